ahb_arbiter: RTL and testbench

- AHB bus arbiter that selects one of NUM_MASTERS requesting masters.
- Drives a one-hot grant vector and the encoded bus-owner index into the AHB address/data multiplexers.
- Re-arbitrates only on bus-ready boundaries.
- Holds ownership for the full length of fixed-length bursts (INCR4/8/16, WRAP4/8/16).

---
 rtl/ahb_pkg.sv | 37 +++
 rtl/ahb_arb_picker.sv | 48 ++++
 rtl/ahb_arbiter.sv | 79 +++++++
 tb/tb_ahb_arbiter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB types and burst-length helper for the arbiter slice.
package ahb_pkg;

  localparam int unsigned AHB_NUM_MASTERS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'b000,
    INCR   = 3'b001,
    WRAP4  = 3'b010,
    INCR4  = 3'b011,
    WRAP8  = 3'b100,
    INCR8  = 3'b101,
    WRAP16 = 3'b110,
    INCR16 = 3'b111
  } hburst_e;

  // Beats remaining after the NONSEQ beat; undefined-length bursts never lock.
  function automatic logic [3:0] burst_beats(hburst_e b);
    logic [3:0] beats;
    beats = '0;
    case (b)
      WRAP4,  INCR4:  beats = 4'd3;
      WRAP8,  INCR8:  beats = 4'd7;
      WRAP16, INCR16: beats = 4'd15;
      default:        beats = '0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb_arb_picker.sv
// Combinational winner selection. AHB_ARB_ROUND_ROBIN_EN selects round-robin,
// otherwise fixed priority with master 0 highest.
module ahb_arb_picker #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned W           = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [W-1:0]           i_ptr,
  output logic [NUM_MASTERS-1:0] o_grant
);

`ifdef AHB_ARB_ROUND_ROBIN_EN
  always_comb begin
    logic             found;
    int unsigned      idx;
    logic [W-1:0]     sel;
    o_grant = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    // Search starts one past the last owner and wraps back onto it last.
    for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
      idx = (32'(i_ptr) + off) % NUM_MASTERS;
      sel = W'(idx);
      if (!found && i_req[sel]) begin
        o_grant[sel] = 1'b1;
        found        = 1'b1;
      end
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  always_comb begin
    logic found;
    o_grant = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!found && i_req[W'(i)]) begin
        o_grant[W'(i)] = 1'b1;
        found          = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter with fixed-length burst lock and park-on-last-owner.
// Define AHB_ARB_ROUND_ROBIN_EN for round-robin selection (default: fixed priority).
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = AHB_NUM_MASTERS
) (
  input  logic                           Hclk,
  input  logic                           Hreset,
  input  logic [NUM_MASTERS-1:0]         Hreq,
  input  logic                           Hready,
  input  logic [1:0]                     Htrans,
  input  logic [2:0]                     Hburst,
  output logic [NUM_MASTERS-1:0]         Hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] Hmaster
);

  localparam int unsigned W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] r_grant;
  logic [W-1:0]           r_master;
  logic [W-1:0]           r_ptr;
  logic [3:0]             r_beats;

  logic [NUM_MASTERS-1:0] w_winner;
  logic [W-1:0]           w_grant_idx;
  logic [W-1:0]           w_winner_idx;
  htrans_e                w_trans;
  hburst_e                w_burst;
  logic                   w_arb;

  assign w_trans = htrans_e'(Htrans);
  assign w_burst = hburst_e'(Hburst);
  // Arbitration uses the pre-edge counter, so a NONSEQ load locks from the next edge.
  assign w_arb   = Hready && (r_beats == '0) && (Hreq != '0);

  ahb_arb_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .W           (W)
  ) u_picker (
    .i_req   (Hreq),
    .i_ptr   (r_ptr),
    .o_grant (w_winner)
  );

  always_comb begin
    w_grant_idx  = '0;
    w_winner_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[W'(i)])  w_grant_idx  = W'(i);
      if (w_winner[W'(i)]) w_winner_idx = W'(i);
    end
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_grant  <= {{(NUM_MASTERS-1){1'b0}}, 1'b1};
      r_master <= '0;
      r_ptr    <= '0;
      r_beats  <= '0;
    end else if (Hready) begin
      r_master <= w_grant_idx;
      if (w_arb) begin
        r_grant <= w_winner;
        r_ptr   <= w_winner_idx;
      end
      case (w_trans)
        NONSEQ:  r_beats <= burst_beats(w_burst);
        SEQ:     if (r_beats != '0) r_beats <= r_beats - 4'd1;
        IDLE:    r_beats <= '0;
        default: ;
      endcase
    end
  end

  assign Hgrant  = r_grant;
  assign Hmaster = r_master;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed self-checking bench for ahb_arbiter; expectations follow AHB_ARB_ROUND_ROBIN_EN.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  logic       Hclk = 1'b0;
  logic       Hreset;
  logic [3:0] Hreq;
  logic       Hready;
  logic [1:0] Htrans;
  logic [2:0] Hburst;
  logic [3:0] Hgrant;
  logic [1:0] Hmaster;

  int n_pass  = 0;
  int n_total = 0;

  ahb_arbiter #(.NUM_MASTERS(4)) dut (
    .Hclk    (Hclk),
    .Hreset  (Hreset),
    .Hreq    (Hreq),
    .Hready  (Hready),
    .Htrans  (Htrans),
    .Hburst  (Hburst),
    .Hgrant  (Hgrant),
    .Hmaster (Hmaster)
  );

  always #5 Hclk = ~Hclk;

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk(input string tag, input logic [3:0] g, input logic [1:0] m);
    check({tag, ".grant"}, 32'(Hgrant), 32'(g));
    check({tag, ".master"}, 32'(Hmaster), 32'(m));
  endtask

`ifdef AHB_ARB_ROUND_ROBIN_EN
  localparam logic [3:0] LOCK_NEXT_G = 4'b1000;
  localparam logic [3:0] RR_SEQ [4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
  localparam logic [3:0] LOCK_NEXT_G = 4'b0001;
  localparam logic [3:0] RR_SEQ [4]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif

  initial begin
    // Reset
    Hreset = 1'b1; Hreq = 4'b0000; Hready = 1'b1; Htrans = IDLE; Hburst = SINGLE;
    step(); step(); step();
    chk("reset", 4'b0001, 2'd0);
    Hreset = 1'b0;
    step();
    chk("reset_release", 4'b0001, 2'd0);

    // Single transfers: grant one edge after request, master one edge later
    Htrans = NONSEQ; Hburst = INCR;
    Hreq = 4'b0001; step(); chk("single0", 4'b0001, 2'd0);
    Hreq = 4'b0010; step(); chk("single1", 4'b0010, 2'd0);
    Hreq = 4'b0100; step(); chk("single2", 4'b0100, 2'd1);
    Hreq = 4'b1000; step(); chk("single3", 4'b1000, 2'd2);
    Hreq = 4'b0000; Htrans = IDLE; step(); chk("park", 4'b1000, 2'd3);

    // Burst lock: master 2 runs INCR4 (with one BUSY) while 1001 requests
    Hreq = 4'b0100; step(); chk("lock_grant", 4'b0100, 2'd3);
    Htrans = NONSEQ; Hburst = INCR4; step(); chk("lock_ns", 4'b0100, 2'd2);
    Hreq = 4'b1001; Htrans = SEQ;
    step(); chk("lock_s1", 4'b0100, 2'd2);
    Htrans = BUSY; step(); chk("lock_busy", 4'b0100, 2'd2);
    Htrans = SEQ;
    step(); chk("lock_s2", 4'b0100, 2'd2);
    step(); chk("lock_s3", 4'b0100, 2'd2);
    Htrans = IDLE; step(); chk("lock_next", LOCK_NEXT_G, 2'd2);

    // Wait states mid-INCR4
    Hreq = 4'b0010; step();
    check("ws_grant", 32'(Hgrant), 32'(4'b0010));
    Htrans = NONSEQ; Hburst = INCR4; step(); chk("ws_ns", 4'b0010, 2'd1);
    Htrans = SEQ; step(); chk("ws_s1", 4'b0010, 2'd1);
    Hready = 1'b0; Hreq = 4'b0001;
    step(); chk("ws_wait1", 4'b0010, 2'd1);
    step(); chk("ws_wait2", 4'b0010, 2'd1);
    Hready = 1'b1;
    step(); chk("ws_s2", 4'b0010, 2'd1);
    step(); chk("ws_s3", 4'b0010, 2'd1);
    Htrans = IDLE; step(); chk("ws_next", 4'b0001, 2'd1);
    Hreq = 4'b0000; step(); chk("ws_park", 4'b0001, 2'd0);

    // Early termination: IDLE mid-INCR8 releases the lock
    Hreq = 4'b0001; Htrans = NONSEQ; Hburst = INCR8; step(); chk("et_ns", 4'b0001, 2'd0);
    Hreq = 4'b0010; Htrans = IDLE; step(); chk("et_idle", 4'b0001, 2'd0);
    step(); chk("et_next", 4'b0010, 2'd0);

    // Reset mid-burst: master 3 on beat 2 of INCR8
    Hreq = 4'b1000; step(); chk("rm_grant", 4'b1000, 2'd1);
    Htrans = NONSEQ; Hburst = INCR8; step(); chk("rm_ns", 4'b1000, 2'd3);
    Htrans = SEQ; step(); chk("rm_s1", 4'b1000, 2'd3);
    Hreset = 1'b1; step(); chk("rm_reset", 4'b0001, 2'd0);
    Hreset = 1'b0; Hreq = 4'b0100; step(); chk("rm_unlocked", 4'b0100, 2'd0);
    Hreq = 4'b0001; Htrans = IDLE; step(); chk("rm_back0", 4'b0001, 2'd2);

    // Fairness with all masters requesting SINGLE transfers
    Hreq = 4'b1111; Htrans = NONSEQ; Hburst = SINGLE;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("rr%0d", i), 32'(Hgrant), 32'(RR_SEQ[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
